mem_stage: RTL and testbench

//  EX/MEM register, load/store unit and MEM/WB register of the 5-stage RV32I pipeline; sits directly downstream of EX.

---
 rtl/mem_stage_if.sv | 12 +
 rtl/mem_stage.sv | 90 +++++++++
 tb/tb_mem_stage.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory req/ready port between the MEM stage and memory
interface mem_stage_if;
  logic req;
  logic we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0] be;
  logic [31:0] rdata;
  logic ready;
  modport master(output req, we, addr, wdata, be, input rdata, ready);
  modport slave(input req, we, addr, wdata, be, output rdata, ready);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM register, load/store unit and MEM/WB register of the RV32I pipeline
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ALUResult_ex,
  input  logic [31:0] MemWriteData_ex,
  input  logic [4:0]  rdAddr_ex,
  input  logic        RegWrite_ex,
  input  logic        MemRead_ex,
  input  logic        MemWrite_ex,
  input  logic        MemtoReg_ex,
  input  logic [2:0]  funct3_ex,
  output logic [31:0] ALUResult_mem,
  output logic [4:0]  rdAddr_mem,
  output logic        RegWrite_mem,
  output logic        stall_mem,
  mem_stage_if.master dmem,
  output logic [31:0] RegWriteData_wb,
  output logic [4:0]  rdAddr_wb,
  output logic        RegWrite_wb,
  output logic        misalign_err,
  output logic        bus_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0] wd_mem, lane, ld;
  logic [2:0] f3_mem;
  logic MemRead_mem, MemWrite_mem, MemtoReg_mem;
  logic mem_op, aligned, abandon, retire;
  // The last allowed ACCESS cycle drops the request and releases the stall.
  always_comb begin
    mem_op = MemRead_mem | MemWrite_mem;
    aligned = f3_mem[1:0] == 2'b00 ||
              (f3_mem[1:0] == 2'b01 ? !ALUResult_mem[0] : ALUResult_mem[1:0] == 2'b00);
    abandon = state == ACCESS && cnt == CW'(TIMEOUT - 1);
    dmem.req = mem_op & aligned & ~abandon;
    stall_mem = dmem.req & ~dmem.ready;
    retire = ~mem_op | (dmem.req & dmem.ready);
    misalign_err = mem_op & ~aligned;
    bus_err = abandon;
    dmem.we = MemWrite_mem;
    dmem.addr = {ALUResult_mem[31:2], 2'b00};
    dmem.be = f3_mem[1:0] == 2'b00 ? 4'b0001 << ALUResult_mem[1:0] :
              f3_mem[1:0] == 2'b01 ? 4'b0011 << ALUResult_mem[1:0] : 4'b1111;
    dmem.wdata = f3_mem[1:0] == 2'b00 ? {4{wd_mem[7:0]}} :
                 f3_mem[1:0] == 2'b01 ? {2{wd_mem[15:0]}} : wd_mem;
    lane = dmem.rdata >> {ALUResult_mem[1:0], 3'b000};
    ld = f3_mem[1:0] == 2'b00 ? {{24{~f3_mem[2] & lane[7]}}, lane[7:0]} :
         f3_mem[1:0] == 2'b01 ? {{16{~f3_mem[2] & lane[15]}}, lane[15:0]} : dmem.rdata;
    state_nx = state == IDLE ? (stall_mem ? ACCESS : IDLE) :
               (dmem.ready | abandon ? IDLE : ACCESS);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      ALUResult_mem <= '0;
      wd_mem <= '0;
      rdAddr_mem <= '0;
      RegWrite_mem <= 1'b0;
      MemRead_mem <= 1'b0;
      MemWrite_mem <= 1'b0;
      MemtoReg_mem <= 1'b0;
      f3_mem <= '0;
      RegWriteData_wb <= '0;
      rdAddr_wb <= '0;
      RegWrite_wb <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= state == ACCESS ? cnt + 1'b1 : '0;
      if (!stall_mem) begin
        ALUResult_mem <= ALUResult_ex;
        wd_mem <= MemWriteData_ex;
        rdAddr_mem <= rdAddr_ex;
        RegWrite_mem <= RegWrite_ex;
        MemRead_mem <= MemRead_ex;
        MemWrite_mem <= MemWrite_ex;
        MemtoReg_mem <= MemtoReg_ex;
        f3_mem <= funct3_ex;
      end
      RegWrite_wb <= retire & RegWrite_mem;
      rdAddr_wb <= retire ? rdAddr_mem : '0;
      RegWriteData_wb <= !retire ? '0 : MemtoReg_mem ? ld : ALUResult_mem;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven scoreboard bench for mem_stage
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] ALUResult_ex, MemWriteData_ex, ALUResult_mem, RegWriteData_wb;
  logic [4:0] rdAddr_ex, rdAddr_mem, rdAddr_wb;
  logic RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex;
  logic [2:0] funct3_ex;
  logic RegWrite_mem, stall_mem, RegWrite_wb, misalign_err, bus_err;
  int checks = 0;
  int failures = 0;
  mem_stage_if bus();
  mem_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ALUResult_ex(ALUResult_ex), .MemWriteData_ex(MemWriteData_ex), .rdAddr_ex(rdAddr_ex),
    .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex), .MemWrite_ex(MemWrite_ex),
    .MemtoReg_ex(MemtoReg_ex), .funct3_ex(funct3_ex),
    .ALUResult_mem(ALUResult_mem), .rdAddr_mem(rdAddr_mem), .RegWrite_mem(RegWrite_mem),
    .stall_mem(stall_mem), .dmem(bus),
    .RegWriteData_wb(RegWriteData_wb), .rdAddr_wb(rdAddr_wb), .RegWrite_wb(RegWrite_wb),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] alu, wd;
    logic [4:0] rd;
    logic rw, mr, mw, m2r;
    logic [2:0] f3;
    int lat;
    logic [31:0] rdata;
    logic req;
    logic [3:0] be;
    logic [31:0] wdata;
    logic mis, berr;
    int stalls;
    logic wrw;
    logic [4:0] wrd;
    logic [31:0] wdat;
  } vec_t;
  vec_t vecs[13];
  vec_t sb[$];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask
  task automatic drive(input vec_t v);
    ALUResult_ex = v.alu;
    MemWriteData_ex = v.wd;
    rdAddr_ex = v.rd;
    RegWrite_ex = v.rw;
    MemRead_ex = v.mr;
    MemWrite_ex = v.mw;
    MemtoReg_ex = v.m2r;
    funct3_ex = v.f3;
  endtask
  task automatic nop();
    vec_t z;
    z = '{default: 0};
    drive(z);
  endtask
  task automatic run_vec(input string n, input vec_t v);
    vec_t e;
    int st;
    logic berr;
    @(negedge clk);
    drive(v);
    sb.push_back(v);
    @(negedge clk);
    nop();
    st = 0;
    berr = 1'b0;
    for (int k = 0; k < 40; k++) begin
      bus.ready = (k == v.lat);
      bus.rdata = v.rdata;
      #1;
      if (k == 0) begin
        chk({n, " req"}, 32'(bus.req), 32'(v.req));
        chk({n, " misalign"}, 32'(misalign_err), 32'(v.mis));
        if (v.req) begin
          chk({n, " be"}, 32'(bus.be), 32'(v.be));
          chk({n, " wdata"}, bus.wdata, v.wdata);
          chk({n, " we"}, 32'(bus.we), 32'(v.mw));
          chk({n, " addr"}, bus.addr, v.alu & 32'hFFFF_FFFC);
        end
      end
      berr = berr | bus_err;
      if (!stall_mem) break;
      st++;
      @(posedge clk);
      #1;
      chk({n, " bubble"}, 32'(RegWrite_wb), 32'd0);
      @(negedge clk);
    end
    chk({n, " stalls"}, 32'(st), 32'(v.stalls));
    chk({n, " bus_err"}, 32'(berr), 32'(v.berr));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({n, " RegWrite_wb"}, 32'(RegWrite_wb), 32'(e.wrw));
    chk({n, " rdAddr_wb"}, 32'(rdAddr_wb), 32'(e.wrd));
    if (e.wrw) chk({n, " wb_data"}, RegWriteData_wb, e.wdat);
    bus.ready = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end
  initial begin
    vec_t v;
    nop();
    bus.ready = 1'b0;
    bus.rdata = '0;
    vecs[0]  = '{32'h12345678, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 0, 32'h0,
                 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 0, 1'b1, 5'd5, 32'h12345678};
    vecs[1]  = '{32'h103, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 0, 32'h80FF0000,
                 1'b1, 4'b1000, 32'h0, 1'b0, 1'b0, 0, 1'b1, 5'd6, 32'hFFFFFF80};
    vecs[2]  = '{32'h102, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 3'b101, 3, 32'h80FF0000,
                 1'b1, 4'b1100, 32'h0, 1'b0, 1'b0, 3, 1'b1, 5'd7, 32'h000080FF};
    vecs[3]  = '{32'h201, 32'hAB, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 0, 32'h0,
                 1'b1, 4'b0010, 32'hABABABAB, 1'b0, 1'b0, 0, 1'b0, 5'd0, 32'h201};
    vecs[4]  = '{32'h202, 32'h1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 0, 32'h0,
                 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 0, 1'b0, 5'd0, 32'h0};
    vecs[5]  = '{32'h300, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 99, 32'h0,
                 1'b1, 4'b1111, 32'h0, 1'b0, 1'b1, 16, 1'b0, 5'd0, 32'h0};
    vecs[6]  = '{32'h100, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 1, 32'h12348001,
                 1'b1, 4'b0011, 32'h0, 1'b0, 1'b0, 1, 1'b1, 5'd10, 32'hFFFF8001};
    vecs[7]  = '{32'h104, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 0, 32'hDEADBEEF,
                 1'b1, 4'b1111, 32'h0, 1'b0, 1'b0, 0, 1'b1, 5'd11, 32'hDEADBEEF};
    vecs[8]  = '{32'h102, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, 3'b100, 0, 32'h00C30000,
                 1'b1, 4'b0100, 32'h0, 1'b0, 1'b0, 0, 1'b1, 5'd12, 32'h000000C3};
    vecs[9]  = '{32'h206, 32'h1234BEEF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 2, 32'h0,
                 1'b1, 4'b1100, 32'hBEEFBEEF, 1'b0, 1'b0, 2, 1'b0, 5'd0, 32'h206};
    vecs[10] = '{32'hFFFFFFFF, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 0, 32'h0,
                 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 0, 1'b1, 5'd0, 32'hFFFFFFFF};
    vecs[11] = '{32'h101, 32'h0, 5'd13, 1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 0, 32'h0,
                 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 0, 1'b0, 5'd0, 32'h0};
    vecs[12] = '{32'h208, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 0, 32'h0,
                 1'b1, 4'b1111, 32'hCAFEF00D, 1'b0, 1'b0, 0, 1'b0, 5'd0, 32'h208};
    repeat (2) @(posedge clk);
    #1;
    chk("rst RegWrite_wb", 32'(RegWrite_wb), 32'd0);
    chk("rst RegWriteData_wb", RegWriteData_wb, 32'd0);
    chk("rst ALUResult_mem", ALUResult_mem, 32'd0);
    chk("rst req", 32'(bus.req), 32'd0);
    chk("rst stall", 32'(stall_mem), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) run_vec($sformatf("vec%0d", i), vecs[i]);
    @(negedge clk);
    v = vecs[0];
    v.alu = 32'h11;
    v.rd = 5'd1;
    drive(v);
    @(posedge clk);
    #1;
    chk("b2b ALUResult_mem", ALUResult_mem, 32'h11);
    chk("b2b rdAddr_mem", 32'(rdAddr_mem), 32'd1);
    chk("b2b RegWrite_mem", 32'(RegWrite_mem), 32'd1);
    @(negedge clk);
    v.alu = 32'h22;
    v.rd = 5'd2;
    drive(v);
    @(posedge clk);
    #1;
    chk("b2b wb1 data", RegWriteData_wb, 32'h11);
    chk("b2b wb1 rd", 32'(rdAddr_wb), 32'd1);
    chk("b2b ALUResult_mem2", ALUResult_mem, 32'h22);
    @(negedge clk);
    nop();
    @(posedge clk);
    #1;
    chk("b2b wb2 data", RegWriteData_wb, 32'h22);
    chk("b2b wb2 rd", 32'(rdAddr_wb), 32'd2);
    @(negedge clk);
    drive(vecs[5]);
    bus.ready = 1'b0;
    @(negedge clk);
    nop();
    repeat (3) @(negedge clk);
    chk("mid stall", 32'(stall_mem), 32'd1);
    chk("mid RegWrite_mem", 32'(RegWrite_mem), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst req", 32'(bus.req), 32'd0);
    chk("arst stall", 32'(stall_mem), 32'd0);
    chk("arst RegWrite_mem", 32'(RegWrite_mem), 32'd0);
    chk("arst RegWrite_wb", 32'(RegWrite_wb), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("post_rst_lw", vecs[7]);
    run_vec("post_rst_add", vecs[0]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
